// File: rtl/multi_chess_timer.sv
// Multi-player chess clock: N_PLAYERS mm:ss countdown timers sharing one
// one-second prescaler, with Fischer increment on each turn switch and
// a flag per player that latches when that player's time runs out.
module multi_chess_timer #(
   parameter int N_PLAYERS = 2,
   parameter int CLK_DIV   = 100000000,
   parameter int INC_SEC   = 0,
   parameter int PW        = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [5:0]               time_in,
   input  logic                     start,
   input  logic                     enable,
   input  logic                     switch,
   output logic [6*N_PLAYERS-1:0]   min,
   output logic [6*N_PLAYERS-1:0]   sec,
   output logic [PW-1:0]            active,
   output logic [N_PLAYERS-1:0]     flag,
   output logic [1:0]               state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int              PRE_W  = $clog2(CLK_DIV);
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_DIV - 1);
   localparam logic [6:0]      INC7   = 7'(INC_SEC);
   localparam logic [PW-1:0]   LAST   = PW'(N_PLAYERS - 1);

   logic [1:0]           r_state, w_next;
   logic [PRE_W-1:0]     r_pre;
   logic [5:0]           r_min [N_PLAYERS];
   logic [5:0]           r_sec [N_PLAYERS];
   logic [PW-1:0]        r_active;
   logic [N_PLAYERS-1:0] r_flag;

   logic       w_run, w_load_ok, w_sw_ok, w_any_flag, w_tick;
   logic [5:0] w_amin, w_asec, w_dmin, w_dsec, w_imin, w_isec, w_load_min;
   logic       w_act_zero, w_dec_zero, w_carry;
   logic [6:0] w_sum_sec, w_sum_min;
   logic [PW-1:0] w_next_active;

   assign w_any_flag = |r_flag;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state: a latched flag in RUN always wins over pause
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (load) w_next = S_IDLE;
                  else if (start) w_next = enable ? S_RUN : S_PAUSE;
         S_RUN:   if (w_any_flag) w_next = S_DONE;
                  else if (!enable) w_next = S_PAUSE;
         S_PAUSE: if (load) w_next = S_IDLE;
                  else if (enable) w_next = S_RUN;
         S_DONE:  if (load) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: which commands are honoured in the current state
   always_comb begin
      w_run     = (r_state == S_RUN);
      w_load_ok = load && (r_state != S_RUN);
      w_sw_ok   = switch && w_run && !w_any_flag;
   end

   assign w_tick = w_run && !w_any_flag && (r_pre == PRE_TC);

   // Prescaler: counts only while staying in RUN, restarts on switch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  r_pre <= '0;
      else if (!w_run || w_next != S_RUN || switch) r_pre <= '0;
      else if (r_pre == PRE_TC)                    r_pre <= '0;
      else                                         r_pre <= r_pre + PRE_W'(1);
   end

   // Select the running player's timer
   always_comb begin
      w_amin = '0;
      w_asec = '0;
      for (int k = 0; k < N_PLAYERS; k++) begin
         if (PW'(k) == r_active) begin
            w_amin = r_min[k];
            w_asec = r_sec[k];
         end
      end
   end

   // Decrement on tick, then Fischer increment with 63:59 saturation
   always_comb begin
      w_act_zero = (w_amin == 6'd0) && (w_asec == 6'd0);
      w_dmin = w_amin;
      w_dsec = w_asec;
      if (w_tick && !w_act_zero) begin
         if (w_asec != 6'd0) begin
            w_dsec = w_asec - 6'd1;
         end else begin
            w_dsec = 6'd59;
            w_dmin = w_amin - 6'd1;
         end
      end
      w_dec_zero = (w_dmin == 6'd0) && (w_dsec == 6'd0);
      w_sum_sec  = {1'b0, w_dsec} + INC7;
      w_carry    = (w_sum_sec >= 7'd60);
      w_isec     = w_carry ? (w_sum_sec[5:0] - 6'd60) : w_sum_sec[5:0];
      w_sum_min  = {1'b0, w_dmin} + {6'd0, w_carry};
      w_imin     = w_sum_min[5:0];
      if (w_sum_min[6]) begin
         w_imin = 6'd63;
         w_isec = 6'd59;
      end
      w_next_active = (r_active == LAST) ? '0 : r_active + PW'(1);
      w_load_min    = (time_in > 6'd59) ? 6'd59 : time_in;
   end

   // Timers, flags and active player: only the active timer ever moves
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_PLAYERS; k++) begin
            r_min[k] <= '0;
            r_sec[k] <= '0;
         end
         r_flag   <= '0;
         r_active <= '0;
      end else if (w_load_ok) begin
         for (int k = 0; k < N_PLAYERS; k++) begin
            r_min[k] <= w_load_min;
            r_sec[k] <= '0;
         end
         r_flag   <= '0;
         r_active <= '0;
      end else if (w_run && !w_any_flag) begin
         for (int k = 0; k < N_PLAYERS; k++) begin
            if (PW'(k) == r_active) begin
               if (w_dec_zero) begin
                  r_min[k]  <= w_dmin;
                  r_sec[k]  <= w_dsec;
                  r_flag[k] <= 1'b1;
               end else if (w_sw_ok) begin
                  r_min[k] <= w_imin;
                  r_sec[k] <= w_isec;
               end else begin
                  r_min[k] <= w_dmin;
                  r_sec[k] <= w_dsec;
               end
            end
         end
         if (!w_dec_zero && w_sw_ok) r_active <= w_next_active;
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_PLAYERS; g++) begin : g_pack
         assign min[6*g +: 6] = r_min[g];
         assign sec[6*g +: 6] = r_sec[g];
      end
   endgenerate

   assign active = r_active;
   assign flag   = r_flag;
   assign state  = r_state;

endmodule

// File: tb/tb_multi_chess_timer.sv
// Directed bench for multi_chess_timer with 3 players, 4-clock second, 5 s increment.
module tb_multi_chess_timer;

   logic        clk = 1'b0;
   logic        reset, load, start, enable, switch;
   logic [5:0]  time_in;
   logic [17:0] min_o, sec_o;
   logic [2:0]  active_o, flag_o;
   logic [1:0]  state_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_chess_timer #(
      .N_PLAYERS(3), .CLK_DIV(4), .INC_SEC(5), .PW(3)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .time_in(time_in),
      .start(start), .enable(enable), .switch(switch),
      .min(min_o), .sec(sec_o), .active(active_o), .flag(flag_o), .state(state_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] tmr(input int k);
      return {20'd0, min_o[6*k +: 6], sec_o[6*k +: 6]};
   endfunction

   function automatic logic [31:0] mmss(input int m, input int s);
      logic [5:0] mm, ss;
      mm = m[5:0];
      ss = s[5:0];
      return {20'd0, mm, ss};
   endfunction

   initial begin
      reset = 1'b0; load = 1'b0; start = 1'b0; enable = 1'b0;
      switch = 1'b0; time_in = 6'd0;
      #2;
      chk("rst_state", state_o, 2'd0);
      chk("rst_min", min_o, 18'd0);
      chk("rst_sec", sec_o, 18'd0);
      chk("rst_flag", flag_o, 3'd0);
      chk("rst_active", active_o, 3'd0);
      step(2);
      reset = 1'b1;
      step(1);

      // basic countdown
      load = 1'b1; time_in = 6'd1; step(1); load = 1'b0;
      chk("load_t0", tmr(0), mmss(1, 0));
      chk("load_state", state_o, 2'd0);
      start = 1'b1; enable = 1'b1; step(1); start = 1'b0;
      chk("start_run", state_o, 2'd1);
      step(3);
      chk("pre_tick_t0", tmr(0), mmss(1, 0));
      step(1);
      chk("tick_t0", tmr(0), mmss(0, 59));
      chk("tick_t1", tmr(1), mmss(1, 0));
      chk("tick_t2", tmr(2), mmss(1, 0));
      chk("tick_active", active_o, 3'd0);

      // increment and wrap of active player
      step(196);
      chk("t0_0010", tmr(0), mmss(0, 10));
      switch = 1'b1; step(1);
      chk("sw1_t0", tmr(0), mmss(0, 15));
      chk("sw1_active", active_o, 3'd1);
      step(1);
      chk("sw2_t1", tmr(1), mmss(1, 5));
      chk("sw2_active", active_o, 3'd2);
      step(1); switch = 1'b0;
      chk("sw3_t2", tmr(2), mmss(1, 5));
      chk("sw3_active", active_o, 3'd0);
      chk("sw3_t0", tmr(0), mmss(0, 15));

      // pause and resume
      enable = 1'b0; step(1);
      chk("pause_state", state_o, 2'd2);
      step(19);
      chk("pause_hold_state", state_o, 2'd2);
      chk("pause_hold_t0", tmr(0), mmss(0, 15));
      enable = 1'b1; step(1);
      chk("resume_state", state_o, 2'd1);
      step(3);
      chk("resume_pre_t0", tmr(0), mmss(0, 15));
      step(1);
      chk("resume_tick_t0", tmr(0), mmss(0, 14));

      // tick coincident with switch at 00:01
      enable = 1'b0; step(1);
      load = 1'b1; time_in = 6'd1; step(1); load = 1'b0;
      chk("reload_state", state_o, 2'd0);
      chk("reload_t0", tmr(0), mmss(1, 0));
      start = 1'b1; enable = 1'b1; step(1); start = 1'b0;
      switch = 1'b1; step(2); switch = 1'b0;
      chk("c_active", active_o, 3'd2);
      chk("c_t0", tmr(0), mmss(1, 5));
      chk("c_t1", tmr(1), mmss(1, 5));
      step(236);
      chk("c_t2_0001", tmr(2), mmss(0, 1));
      step(3);
      switch = 1'b1; step(1); switch = 1'b0;
      chk("c_t2_zero", tmr(2), mmss(0, 0));
      chk("c_flag", flag_o, 3'b100);
      chk("c_active_hold", active_o, 3'd2);
      step(1);
      chk("c_done", state_o, 2'd3);
      switch = 1'b1; step(1); switch = 1'b0;
      chk("c_done_sw_active", active_o, 3'd2);
      chk("c_done_t0", tmr(0), mmss(1, 5));

      // zero load then start
      load = 1'b1; time_in = 6'd0; step(1); load = 1'b0;
      chk("d_state", state_o, 2'd0);
      chk("d_flag_clr", flag_o, 3'd0);
      chk("d_active", active_o, 3'd0);
      start = 1'b1; enable = 1'b1; step(1); start = 1'b0;
      chk("d_run", state_o, 2'd1);
      step(1);
      chk("d_flag", flag_o, 3'b001);
      step(1);
      chk("d_done", state_o, 2'd3);
      switch = 1'b1; start = 1'b1; step(1); switch = 1'b0; start = 1'b0;
      step(1);
      chk("d_ign_active", active_o, 3'd0);
      chk("d_ign_state", state_o, 2'd3);
      chk("d_ign_flag", flag_o, 3'b001);
      chk("d_ign_t0", tmr(0), mmss(0, 0));

      // clamp, saturation, ignored load in RUN
      load = 1'b1; time_in = 6'd63; step(1); load = 1'b0;
      chk("e_load_t0", tmr(0), mmss(59, 0));
      chk("e_load_t2", tmr(2), mmss(59, 0));
      enable = 1'b0; start = 1'b1; step(1); start = 1'b0;
      chk("e_start_pause", state_o, 2'd2);
      enable = 1'b1; step(1);
      chk("e_run", state_o, 2'd1);
      load = 1'b1; time_in = 6'd2; step(1); load = 1'b0;
      chk("e_load_ign_state", state_o, 2'd1);
      chk("e_load_ign_t0", tmr(0), mmss(59, 0));
      switch = 1'b1; step(180); switch = 1'b0;
      chk("e_sat_t0", tmr(0), mmss(63, 59));
      chk("e_sat_active", active_o, 3'd0);
      step(4);
      chk("e_t0_6358", tmr(0), mmss(63, 58));
      switch = 1'b1; step(1); switch = 1'b0;
      chk("e_sat2_t0", tmr(0), mmss(63, 59));
      chk("e_sat2_t1", tmr(1), mmss(63, 59));
      chk("e_sat2_active", active_o, 3'd1);

      // asynchronous reset between clock edges
      #3; reset = 1'b0; #1;
      chk("ar_state", state_o, 2'd0);
      chk("ar_min", min_o, 18'd0);
      chk("ar_sec", sec_o, 18'd0);
      chk("ar_flag", flag_o, 3'd0);
      chk("ar_active", active_o, 3'd0);
      reset = 1'b1;
      step(3);
      chk("ar_stay_idle", state_o, 2'd0);
      chk("ar_stay_t1", tmr(1), mmss(0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
